multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle successor to the single-cycle opcode decoder. FSM sequences FETCH/DECODE/EXEC/MEM/WB
//  and drives the datapath strobes per state. Adds a variable-latency memory handshake, a memory
//  timeout, and an illegal-opcode trap. Sits between instruction fetch, ALU/regfile datapath and data memory.
// PARAMETERS
//  OPCODE_W     6   opcode width
//  ALUOP_W      2   alu_op width
//  MEM_TIMEOUT  15  max MEM cycles waiting for mem_ready before abort (>=1)
// PORTS
//  clk          in   1         single clock, rising edge
//  rst_n        in   1         asynchronous, active-low reset
//  opcode       in   OPCODE_W  instruction opcode; sampled when opcode_valid && ir_write
//  opcode_valid in   1         fetch has an instruction available
//  mem_ready    in   1         data memory completes the current access this cycle
//  ir_write     out  1         instruction accepted (fetch handshake ready)
//  pc_write     out  1         advance PC, 1-cycle pulse at instruction retire/abort
//  reg_dst      out  1         1=rd, 0=rt
//  alu_src      out  1         1=immediate, 0=register
//  alu_op       out  ALUOP_W   ALU function select
//  mem_read     out  1         load access, held until mem_ready
//  mem_write    out  1         store access, held until mem_ready
//  reg_write    out  1         regfile write enable
//  mem_to_reg   out  1         1=write-back from memory
//  illegal_op   out  1         1-cycle pulse: undefined opcode trapped
//  mem_err      out  1         1-cycle pulse: memory timeout abort
//  busy         out  1         high in every state except FETCH
// BEHAVIOUR
//  Reset: state=FETCH, opcode latch=0, timeout counter=0; all outputs 0 (ir_write follows opcode_valid).
//  Outputs are decoded from state and the latched opcode (Moore). Outputs not listed for a state are 0.
//  Opcode table (class, alu_op): 1=R,2; 3=R,3; 5=R,0; 7=R,1; 4=LW,2; 2=SW,2; all others ILLEGAL.
//  FETCH: ir_write=opcode_valid; on valid, latch opcode -> DECODE; otherwise stay.
//  DECODE: R/LW/SW -> EXEC. ILLEGAL: illegal_op=1, pc_write=1 -> FETCH. No reg/mem writes occur.
//  EXEC: alu_op per table; alu_src=1 for LW/SW, 0 for R; reg_dst=1 for R. R -> WB; LW/SW -> MEM
//    (counter cleared).
//  MEM: alu_src=1, alu_op=2; mem_read=LW, mem_write=SW held continuously.
//    mem_ready=1: SW -> FETCH with pc_write=1; LW -> WB.
//    mem_ready=0: counter++. When counter==MEM_TIMEOUT-1 and still not ready: mem_err=1, pc_write=1
//      -> FETCH. mem_ready on the same cycle as the timeout boundary wins (normal completion).
//  WB: reg_write=1, pc_write=1; R: reg_dst=1, mem_to_reg=0, alu_op per table held; LW: reg_dst=0,
//    mem_to_reg=1 -> FETCH.
//  Latency after the accept cycle: R = 3 cycles (DECODE, EXEC, WB); SW = 2+n; LW = 3+n, where
//    n = number of MEM cycles (>=1).
//  opcode is ignored outside FETCH. opcode_valid held high gives back-to-back accepts (one per retire).
//  Reset mid-instruction: immediate return to FETCH; no partial strobes persist.
//  Counter width = $clog2(MEM_TIMEOUT+1); it never wraps (reset on entry to MEM).
// STRUCTURE
//  Shared package mcu_pkg: state enum (FETCH, DECODE, EXEC, MEM, WB), opcode localparams
//    (OP_ADD=1, OP_SUB=3, OP_AND=5, OP_OR=7, OP_LW=4, OP_SW=2), ALUOp encodings, class enum (R, LW, SW, ILLEGAL).
//  Sub-module mcu_opcode_decode: combinational, opcode -> {class, alu_op}; instantiated once on the
//    latched opcode.
//  Top: state register, opcode latch, timeout counter, output decode.
// TESTING
//  1. Reset released, opcode_valid=0 -> stays in FETCH, busy=0, all strobes 0.
//  2. opcode=1 valid -> DECODE, EXEC(alu_op=2, alu_src=0), WB(reg_write=1, reg_dst=1, pc_write=1); 4 cycles total.
//  3. opcode=4, mem_ready high on 3rd MEM cycle -> mem_read high exactly 3 cycles; WB mem_to_reg=1, reg_dst=0.
//  4. opcode=2, mem_ready never -> mem_write high 15 cycles; mem_err + pc_write pulse; back in FETCH; reg_write never set.
//  5. opcode=6 -> illegal_op + pc_write pulse in DECODE; no mem/reg strobes; next opcode=7 yields alu_op=1.
//  6. rst_n low during MEM of a load -> all outputs 0 asynchronously; FETCH on release.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and constants for the multi-cycle control unit: FSM states, opcode values,
// ALU function encodings and instruction classes.
package mcu_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    typedef enum logic [1:0] {
        ClsR,
        ClsLw,
        ClsSw,
        ClsIllegal
    } op_class_e;

    localparam int unsigned OP_ADD = 1;
    localparam int unsigned OP_SUB = 3;
    localparam int unsigned OP_AND = 5;
    localparam int unsigned OP_OR  = 7;
    localparam int unsigned OP_LW  = 4;
    localparam int unsigned OP_SW  = 2;

    localparam logic [1:0] ALUOP_AND = 2'd0;
    localparam logic [1:0] ALUOP_OR  = 2'd1;
    localparam logic [1:0] ALUOP_ADD = 2'd2;
    localparam logic [1:0] ALUOP_SUB = 2'd3;

endpackage

// File: rtl/mcu_opcode_decode.sv
// Combinational opcode classifier: maps an opcode to its instruction class and ALU function.
module mcu_opcode_decode
    import mcu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 2
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [1:0]          op_class,
    output logic [ALUOP_W-1:0]  alu_op
);

    always_comb begin
        op_class = ClsIllegal;
        alu_op   = '0;
        case (opcode)
            OPCODE_W'(OP_ADD): begin op_class = ClsR;  alu_op = ALUOP_W'(ALUOP_ADD); end
            OPCODE_W'(OP_SUB): begin op_class = ClsR;  alu_op = ALUOP_W'(ALUOP_SUB); end
            OPCODE_W'(OP_AND): begin op_class = ClsR;  alu_op = ALUOP_W'(ALUOP_AND); end
            OPCODE_W'(OP_OR):  begin op_class = ClsR;  alu_op = ALUOP_W'(ALUOP_OR);  end
            OPCODE_W'(OP_LW):  begin op_class = ClsLw; alu_op = ALUOP_W'(ALUOP_ADD); end
            OPCODE_W'(OP_SW):  begin op_class = ClsSw; alu_op = ALUOP_W'(ALUOP_ADD); end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with variable-latency memory handshake,
// memory timeout abort and illegal-opcode trap.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                opcode_valid,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_dst,
    output logic                alu_src,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                illegal_op,
    output logic                mem_err,
    output logic                busy
);

    localparam int unsigned    CntW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [OPCODE_W-1:0]   opcode_q;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [1:0]            op_class;
    logic [ALUOP_W-1:0]    dec_alu_op;

    mcu_opcode_decode #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W)
    ) u_decode (
        .opcode   (opcode_q),
        .op_class (op_class),
        .alu_op   (dec_alu_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StFetch;
            opcode_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StFetch && opcode_valid) begin
                opcode_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        busy       = (state_q != StFetch);

        case (state_q)
            StFetch: begin
                ir_write = opcode_valid;
                if (opcode_valid) state_d = StDecode;
            end
            StDecode: begin
                if (op_class == ClsIllegal) begin
                    illegal_op = 1'b1;
                    pc_write   = 1'b1;
                    state_d    = StFetch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_op  = dec_alu_op;
                alu_src = (op_class != ClsR);
                reg_dst = (op_class == ClsR);
                if (op_class == ClsR) begin
                    state_d = StWb;
                end else begin
                    state_d = StMem;
                    cnt_d   = '0;
                end
            end
            StMem: begin
                alu_src   = 1'b1;
                alu_op    = ALUOP_W'(ALUOP_ADD);
                mem_read  = (op_class == ClsLw);
                mem_write = (op_class == ClsSw);
                // A ready on the timeout boundary cycle still completes normally.
                if (mem_ready) begin
                    if (op_class == ClsSw) begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (cnt_q == CntLast) begin
                    mem_err  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StFetch;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (op_class == ClsR) begin
                    reg_dst = 1'b1;
                    alu_op  = dec_alu_op;
                end else begin
                    mem_to_reg = 1'b1;
                end
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected strobe traces built from the
// opcode table and memory-latency rules, compared cycle by cycle.
module tb_multicycle_control_unit;

    localparam int unsigned TMO = 15;

    // Bit positions inside the packed strobe vector.
    localparam int B_IR = 12, B_PC = 11, B_RD = 10, B_AS = 9, B_MR = 6, B_MW = 5;
    localparam int B_RW = 4, B_MTR = 3, B_ILL = 2, B_ERR = 1, B_BUSY = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       opcode_valid = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_write, pc_write, reg_dst, alu_src, mem_read, mem_write;
    logic       reg_write, mem_to_reg, illegal_op, mem_err, busy;
    logic [1:0] alu_op;
    logic [12:0] dut_vec;

    int vectors = 0;
    int miscompares = 0;

    multicycle_control_unit #(
        .OPCODE_W    (6),
        .ALUOP_W     (2),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .mem_ready    (mem_ready),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .reg_dst      (reg_dst),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .illegal_op   (illegal_op),
        .mem_err      (mem_err),
        .busy         (busy)
    );

    assign dut_vec = {ir_write, pc_write, reg_dst, alu_src, alu_op, mem_read, mem_write,
                      reg_write, mem_to_reg, illegal_op, mem_err, busy};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 0 = R-type, 1 = load, 2 = store, 3 = illegal
    function automatic int classify(input logic [5:0] op, output logic [1:0] aop);
        aop = 2'd0;
        case (op)
            6'd1: begin aop = 2'd2; return 0; end
            6'd3: begin aop = 2'd3; return 0; end
            6'd5: begin aop = 2'd0; return 0; end
            6'd7: begin aop = 2'd1; return 0; end
            6'd4: begin aop = 2'd2; return 1; end
            6'd2: begin aop = 2'd2; return 2; end
            default: return 3;
        endcase
    endfunction

    // ready_at: MEM cycle number (1-based) on which mem_ready rises; 0 or >TMO means never.
    task automatic run_instr(input logic [5:0] op, input int ready_at, input int idle,
                             input bit hold, input string name);
        logic [12:0] expq[$];
        logic        vq[$];
        logic        rq[$];
        logic [12:0] v;
        logic [1:0]  aop;
        int          cls;
        int          acc;
        bit          done;
        bit          rdy;

        cls = classify(op, aop);
        for (int i = 0; i < idle; i++) begin
            expq.push_back('0); vq.push_back(1'b0); rq.push_back(1'($urandom));
        end
        acc = idle;
        v = '0; v[B_IR] = 1'b1;
        expq.push_back(v); vq.push_back(1'b1); rq.push_back(1'($urandom));

        v = '0; v[B_BUSY] = 1'b1;
        if (cls == 3) begin v[B_ILL] = 1'b1; v[B_PC] = 1'b1; end
        expq.push_back(v); vq.push_back(hold | 1'($urandom)); rq.push_back(1'($urandom));

        if (cls != 3) begin
            v = '0; v[B_BUSY] = 1'b1; v[8:7] = aop;
            if (cls == 0) v[B_RD] = 1'b1; else v[B_AS] = 1'b1;
            expq.push_back(v); vq.push_back(hold | 1'($urandom)); rq.push_back(1'($urandom));
        end

        if (cls == 0) begin
            v = '0; v[B_BUSY] = 1'b1; v[B_RW] = 1'b1; v[B_PC] = 1'b1; v[B_RD] = 1'b1;
            v[8:7] = aop;
            expq.push_back(v); vq.push_back(hold | 1'($urandom)); rq.push_back(1'($urandom));
        end else if (cls != 3) begin
            done = 1'b0;
            for (int k = 1; k <= TMO && !done; k++) begin
                rdy = (k == ready_at);
                v = '0; v[B_BUSY] = 1'b1; v[B_AS] = 1'b1; v[8:7] = 2'd2;
                if (cls == 1) v[B_MR] = 1'b1; else v[B_MW] = 1'b1;
                if (rdy && cls == 2) v[B_PC] = 1'b1;
                if (!rdy && k == TMO) begin v[B_ERR] = 1'b1; v[B_PC] = 1'b1; end
                expq.push_back(v); vq.push_back(hold | 1'($urandom)); rq.push_back(rdy);
                if (rdy) done = 1'b1;
            end
            if (cls == 1 && done) begin
                v = '0; v[B_BUSY] = 1'b1; v[B_RW] = 1'b1; v[B_PC] = 1'b1; v[B_MTR] = 1'b1;
                expq.push_back(v); vq.push_back(hold | 1'($urandom)); rq.push_back(1'($urandom));
            end
        end

        for (int i = 0; i < expq.size(); i++) begin
            opcode_valid = vq[i];
            opcode       = (i == acc) ? op : 6'($urandom);
            mem_ready    = rq[i];
            #1;
            vectors++;
            if (dut_vec !== expq[i]) begin
                miscompares++;
                $display("FAIL %s op=%0d cycle %0d: got %b expected %b", name, op, i - acc,
                         dut_vec, expq[i]);
            end
            step();
        end
        opcode_valid = 1'b0;
    endtask

    task automatic check_vec(input logic [12:0] expv, input string name);
        vectors++;
        if (dut_vec !== expv) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, dut_vec, expv);
        end
    endtask

    task automatic test_reset();
        logic [12:0] v;
        rst_n = 1'b0; opcode_valid = 1'b0; mem_ready = 1'($urandom);
        #2;
        check_vec('0, "reset_idle");
        opcode_valid = 1'b1;
        #1;
        v = '0; v[B_IR] = 1'b1;
        check_vec(v, "reset_ir_follows_valid");
        opcode_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            opcode = 6'($urandom); mem_ready = 1'($urandom);
            #1;
            check_vec('0, "idle_after_reset");
            step();
        end
    endtask

    task automatic test_r_type();
        run_instr(6'd1, 0, 1, 1'b0, "r_add");
        run_instr(6'd3, 0, 0, 1'b0, "r_sub");
    endtask

    task automatic test_load();
        run_instr(6'd4, 3, 1, 1'b0, "lw_ready3");
        run_instr(6'd4, TMO, 0, 1'b0, "lw_ready_on_boundary");
        run_instr(6'd4, 0, 0, 1'b0, "lw_timeout");
    endtask

    task automatic test_store_timeout();
        run_instr(6'd2, 0, 2, 1'b0, "sw_timeout");
        run_instr(6'd2, 1, 0, 1'b0, "sw_ready1");
    endtask

    task automatic test_illegal();
        run_instr(6'd6, 0, 1, 1'b0, "illegal6");
        run_instr(6'd7, 0, 0, 1'b0, "r_or_after_illegal");
        run_instr(6'd0, 0, 0, 1'b0, "illegal0");
    endtask

    task automatic test_reset_mid();
        logic [12:0] v;
        opcode = 6'd4; opcode_valid = 1'b1; mem_ready = 1'b0;
        step();
        opcode_valid = 1'b0;
        step(); step();
        step();
        #1;
        v = '0; v[B_BUSY] = 1'b1; v[B_AS] = 1'b1; v[8:7] = 2'd2; v[B_MR] = 1'b1;
        check_vec(v, "mid_load_mem");
        #2;
        rst_n = 1'b0;
        #1;
        check_vec('0, "async_reset_in_mem");
        step(); step();
        rst_n = 1'b1;
        #1;
        check_vec('0, "fetch_after_reset");
        step();
        run_instr(6'd5, 0, 0, 1'b0, "r_and_after_reset");
    endtask

    task automatic test_back_to_back();
        run_instr(6'd1, 0, 0, 1'b1, "b2b_add");
        run_instr(6'd4, 2, 0, 1'b1, "b2b_lw");
        run_instr(6'd2, 4, 0, 1'b1, "b2b_sw");
        run_instr(6'd9, 0, 0, 1'b1, "b2b_illegal");
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: op = 6'($urandom);
                1: op = 6'd4;
                2: op = 6'd2;
                default: op = 6'(2 * $urandom_range(0, 3) + 1);
            endcase
            run_instr(op, int'($urandom_range(0, TMO + 3)), int'($urandom_range(0, 2)),
                      1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load();
        test_store_timeout();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
